burst_slave_port: RTL and testbench
===================================

# burst_slave_port

Serial-bus slave port with burst transfers and a configurable memory read latency. It sits between the serial system bus (master port side) and a synchronous slave memory. It deserialises an address and a burst length from the master, then performs 1 to 2^BURST_WIDTH consecutive memory writes or reads at incrementing addresses. Read data is serialised back to the master.

## Interface
- ADDR_WIDTH, 12, memory address width; must be ≥ 2.
- DATA_WIDTH, 8, memory word width; must be ≥ 2.
- BURST_WIDTH, 4, width of the burst length field; beats = len + 1; must be ≥ 1.
- MEM_LATENCY, 1, cycles from an smemren cycle to the cycle in which smemrdata is valid; must be ≥ 1.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- smemrdata  in  DATA_WIDTH  read data from memory.
- smemwen  out  1  memory write strobe, one cycle per beat.
- smemren  out  1  memory read strobe, one cycle per beat.
- smemaddr  out  ADDR_WIDTH  memory address.
- smemwdata  out  DATA_WIDTH  memory write data.
- swdata  in  1  serial address/length/write-data bit from master.
- smode  in  1  0 = read, 1 = write; sampled only with the first address bit.
- mvalid  in  1  swdata valid this cycle.
- srdata  out  1  serial read data bit to master.
- svalid  out  1  srdata valid this cycle.
- sready  out  1  combinational; high exactly when the state is IDLE.

## Operation
- States:
  - IDLE: sready = 1.
  - ADDR: receiving address bits.
  - LEN: receiving burst length bits.
  - WDATA: receiving write data bits.
  - RWAIT: waiting for memory read data.
  - RDATA: sending read data bits.
- Serial order: all fields are sent LSB first. Order on the wire is address (ADDR_WIDTH bits), then len (BURST_WIDTH bits), then, for writes only, (len+1)×DATA_WIDTH data bits.
- IDLE: on mvalid = 1:
  - capture smode into mode;
  - capture swdata as addr[0];
  - set bit counter to 1;
  - go to ADDR.
- ADDR, LEN, WDATA: a bit is accepted only in a cycle where mvalid = 1. When mvalid = 0 the state, counters and registers hold (stall).
- ADDR: after bit ADDR_WIDTH-1, clear the counter and go to LEN.
- LEN: after bit BURST_WIDTH-1, clear the beat counter.
  - If mode = 1: go to WDATA.
  - If mode = 0: go to RWAIT and issue the first read.
- Write beat: at the edge sampling the last data bit, register smemwen = 1, smemaddr = current addr, and smemwdata = the assembled word.
  - If beat == len: go to IDLE.
  - Otherwise: increment beat and addr, and stay in WDATA.
- Read beat: issue = registered smemren = 1 with smemaddr = current addr, for one cycle.
  - RWAIT counts MEM_LATENCY cycles, then loads smemrdata into the shift register and enters RDATA.
  - RDATA drives DATA_WIDTH bits LSB first with svalid = 1. mvalid is ignored during RDATA; the master must accept every bit.
  - After the last bit: if beat == len, go to IDLE. Otherwise increment beat and addr, then issue the next read.
- Address increments modulo 2^ADDR_WIDTH (0xFFF + 1 → 0x000).
- mvalid is ignored in RWAIT and RDATA.
- smemwdata and smemaddr hold their last value when not strobed.

## Timing
- Reset: at any state, with rstn = 0 at a clock edge:
  - state → IDLE;
  - smemwen, smemren, svalid, srdata = 0;
  - smemaddr, smemwdata, addr, len, counters = 0.
  - sready = 1 from the following cycle.
- Reset mid-burst aborts the burst. No further strobes are issued.
- Write:
  - smemwen is high for exactly the one cycle after the edge that samples the last bit of each beat.
  - The first bit of the next beat may be sampled in that same cycle.
  - After the final beat, sready = 1 in the same cycle as the last smemwen.
- Read:
  - Let C be the cycle in which smemren = 1.
  - smemrdata is sampled at the end of cycle C+MEM_LATENCY.
  - srdata bit i with svalid = 1 appears in cycle C+MEM_LATENCY+1+i.
  - The next beat's smemren is in cycle C+MEM_LATENCY+DATA_WIDTH+1, during which svalid = 0.
  - Beat period is DATA_WIDTH+MEM_LATENCY+1 cycles.
- First read: smemren is high in the cycle after the edge that samples the last len bit.
- End of read burst: svalid = 0 and sready = 1 in the cycle after the last srdata bit.
- smemwen and smemren are never both high.
- smemren is never high outside the read issue cycle.

## Test plan
- Single write: mode=1, addr=0x0A5, len=0, data=0x3C, mvalid continuous → exactly one smemwen pulse with smemaddr=0x0A5 and smemwdata=0x3C; sready high again in that same cycle.
- Single read, MEM_LATENCY=1: addr=0x0A5, len=0, memory returns 0x3C → smemren one cycle with smemaddr=0x0A5; srdata 0,0,1,1,1,1,0,0 with svalid high for 8 cycles starting 2 cycles after smemren; then sready=1.
- Burst write with wrap: addr=0xFFE, len=3, data 0x11/0x22/0x33/0x44 → four smemwen pulses at addresses 0xFFE, 0xFFF, 0x000, 0x001 with matching data, 8 cycles apart.
- Burst read, MEM_LATENCY=3: addr=0x010, len=1 → smemren at C and C+12; svalid high during C+4..C+11 and C+16..C+23; returned words appear correctly.
- Stall: mvalid dropped for 5 cycles after address bit 4 and again mid-data → final address and data are unchanged versus the unstalled run; smemwen is delayed by exactly 10 cycles.
- Reset mid-read: rstn low during RDATA bit 3 → next cycle svalid=0, srdata=0, sready=1, no smemren; a subsequent write completes normally.

Source files
------------

// File: rtl/burst_slave_port.sv
// Serial-bus slave port: deserialises addr/len (+write data) and runs 1..2^BURST_WIDTH memory beats.
// Read beat period DATA_WIDTH+MEM_LATENCY+1 cycles; serial input stalls on mvalid=0, read data is never stalled.
module burst_slave_port #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 8,
    parameter int BURST_WIDTH = 4,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] smemrdata,
    output logic                  smemwen,
    output logic                  smemren,
    output logic [ADDR_WIDTH-1:0] smemaddr,
    output logic [DATA_WIDTH-1:0] smemwdata,
    input  logic                  swdata,
    input  logic                  smode,
    input  logic                  mvalid,
    output logic                  srdata,
    output logic                  svalid,
    output logic                  sready
);

    localparam int M1 = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int M2 = (M1 > BURST_WIDTH) ? M1 : BURST_WIDTH;
    localparam int M3 = (M2 > MEM_LATENCY + 1) ? M2 : MEM_LATENCY + 1;
    localparam int CW = $clog2(M3);

    localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] L_LAST = CW'(BURST_WIDTH - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] LAT    = CW'(MEM_LATENCY);

    typedef enum logic [2:0] {IDLE, ADDR, LEN, WDATA, RWAIT, RDATA} state_t;

    state_t                 state;
    logic                   mode;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [BURST_WIDTH-1:0] len;
    logic [BURST_WIDTH-1:0] beat;
    logic [CW-1:0]          cnt;
    logic [DATA_WIDTH-1:0]  shreg;

    assign sready = (state == IDLE);

    // Serial fields enter at the MSB and shift down, so after N bits bit 0 sits at the LSB.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            mode      <= 1'b0;
            addr      <= '0;
            len       <= '0;
            beat      <= '0;
            cnt       <= '0;
            shreg     <= '0;
            smemwen   <= 1'b0;
            smemren   <= 1'b0;
            smemaddr  <= '0;
            smemwdata <= '0;
            srdata    <= 1'b0;
            svalid    <= 1'b0;
        end else begin
            smemwen <= 1'b0;
            smemren <= 1'b0;
            case (state)
                IDLE: begin
                    if (mvalid) begin
                        mode  <= smode;
                        addr  <= {swdata, addr[ADDR_WIDTH-1:1]};
                        cnt   <= CW'(1);
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (mvalid) begin
                        addr <= {swdata, addr[ADDR_WIDTH-1:1]};
                        if (cnt == A_LAST) begin
                            cnt   <= '0;
                            state <= LEN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                LEN: begin
                    if (mvalid) begin
                        len <= (len >> 1) | (BURST_WIDTH'(swdata) << (BURST_WIDTH - 1));
                        if (cnt == L_LAST) begin
                            cnt  <= '0;
                            beat <= '0;
                            if (mode) begin
                                state <= WDATA;
                            end else begin
                                state    <= RWAIT;
                                smemren  <= 1'b1;
                                smemaddr <= addr;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                WDATA: begin
                    if (mvalid) begin
                        shreg <= {swdata, shreg[DATA_WIDTH-1:1]};
                        if (cnt == D_LAST) begin
                            cnt       <= '0;
                            smemwen   <= 1'b1;
                            smemaddr  <= addr;
                            smemwdata <= {swdata, shreg[DATA_WIDTH-1:1]};
                            if (beat == len) begin
                                state <= IDLE;
                            end else begin
                                beat <= beat + 1'b1;
                                addr <= addr + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RWAIT: begin
                    // The issue cycle counts as 0, so data is taken MEM_LATENCY cycles after smemren.
                    if (cnt == LAT) begin
                        cnt    <= '0;
                        shreg  <= smemrdata;
                        srdata <= smemrdata[0];
                        svalid <= 1'b1;
                        state  <= RDATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RDATA: begin
                    shreg <= shreg >> 1;
                    if (cnt == D_LAST) begin
                        cnt    <= '0;
                        svalid <= 1'b0;
                        srdata <= 1'b0;
                        if (beat == len) begin
                            state <= IDLE;
                        end else begin
                            beat     <= beat + 1'b1;
                            addr     <= addr + 1'b1;
                            smemren  <= 1'b1;
                            smemaddr <= addr + 1'b1;
                            state    <= RWAIT;
                        end
                    end else begin
                        cnt    <= cnt + 1'b1;
                        srdata <= shreg[1];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_slave_port.sv
// Directed bench: one port with MEM_LATENCY=1 and one with MEM_LATENCY=3, each behind a small memory model.
module tb_burst_slave_port;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int BW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, swdata, smode, mv, sel3;
    logic mvalid1, mvalid3;
    assign mvalid1 = mv & ~sel3;
    assign mvalid3 = mv & sel3;

    logic [DW-1:0] rd1, rd3, wd1, wd3, p0, p1, p2;
    logic [AW-1:0] ad1, ad3;
    logic wen1, ren1, srd1, sv1, rdy1;
    logic wen3, ren3, srd3, sv3, rdy3;
    logic [7:0] mem1 [4096];
    logic [7:0] mem3 [4096];

    int n_cmp = 0;
    int n_fail = 0;

    burst_slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW), .MEM_LATENCY(1)) dut (
        .clk(clk), .rstn(rstn), .smemrdata(rd1), .smemwen(wen1), .smemren(ren1),
        .smemaddr(ad1), .smemwdata(wd1), .swdata(swdata), .smode(smode), .mvalid(mvalid1),
        .srdata(srd1), .svalid(sv1), .sready(rdy1));

    burst_slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .rstn(rstn), .smemrdata(rd3), .smemwen(wen3), .smemren(ren3),
        .smemaddr(ad3), .smemwdata(wd3), .swdata(swdata), .smode(smode), .mvalid(mvalid3),
        .srdata(srd3), .svalid(sv3), .sready(rdy3));

    always @(posedge clk) begin
        if (wen1) mem1[ad1] <= wd1;
        if (ren1) rd1 <= mem1[ad1];
        if (wen3) mem3[ad3] <= wd3;
        p0 <= ren3 ? mem3[ad3] : 8'h00;
        p1 <= p0;
        p2 <= p1;
    end
    assign rd3 = p2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input logic v);
        swdata = b;
        mv = v;
        tick();
    endtask

    task automatic send_hdr(input logic m, input logic [AW-1:0] a, input logic [BW-1:0] l);
        smode = m;
        for (int i = 0; i < AW; i++) drive_bit(a[i], 1'b1);
        for (int i = 0; i < BW; i++) drive_bit(l[i], 1'b1);
        mv = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; mv = 1'b0; sel3 = 1'b0; swdata = 1'b0; smode = 1'b0;
        tick(); tick();
        n_cmp++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL rst_sready: got %b want 1", rdy1); end
        n_cmp++; if (wen1 !== 1'b0) begin n_fail++; $display("FAIL rst_wen: got %b want 0", wen1); end
        n_cmp++; if (ren1 !== 1'b0) begin n_fail++; $display("FAIL rst_ren: got %b want 0", ren1); end
        n_cmp++; if (sv1 !== 1'b0) begin n_fail++; $display("FAIL rst_svalid: got %b want 0", sv1); end
        n_cmp++; if (srd1 !== 1'b0) begin n_fail++; $display("FAIL rst_srdata: got %b want 0", srd1); end
        n_cmp++; if (ad1 !== 12'h000) begin n_fail++; $display("FAIL rst_addr: got %h want 000", ad1); end
        n_cmp++; if (wd1 !== 8'h00) begin n_fail++; $display("FAIL rst_wdata: got %h want 00", wd1); end
        n_cmp++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL rst_sready3: got %b want 1", rdy3); end
        rstn = 1'b1;
        tick();
        n_cmp++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b want 1", rdy1); end
    endtask

    task automatic test_single_write();
        logic [7:0] d;
        d = 8'h3C;
        sel3 = 1'b0;
        send_hdr(1'b1, 12'h0A5, 4'd0);
        for (int i = 0; i < DW; i++) begin
            drive_bit(d[i], 1'b1);
            if (i < DW - 1) begin
                n_cmp++; if (wen1 !== 1'b0) begin n_fail++; $display("FAIL wr1_early bit%0d: got %b want 0", i, wen1); end
            end
        end
        mv = 1'b0;
        n_cmp++; if (wen1 !== 1'b1) begin n_fail++; $display("FAIL wr1_wen: got %b want 1", wen1); end
        n_cmp++; if (ad1 !== 12'h0A5) begin n_fail++; $display("FAIL wr1_addr: got %h want 0a5", ad1); end
        n_cmp++; if (wd1 !== 8'h3C) begin n_fail++; $display("FAIL wr1_data: got %h want 3c", wd1); end
        n_cmp++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL wr1_sready: got %b want 1", rdy1); end
        tick();
        n_cmp++; if (wen1 !== 1'b0) begin n_fail++; $display("FAIL wr1_pulse_len: got %b want 0", wen1); end
    endtask

    task automatic test_single_read();
        logic [7:0] d;
        logic esv;
        d = 8'h3C;
        mem1[12'h0A5] = 8'h3C;
        sel3 = 1'b0;
        send_hdr(1'b0, 12'h0A5, 4'd0);
        n_cmp++; if (ren1 !== 1'b1) begin n_fail++; $display("FAIL rd1_ren: got %b want 1", ren1); end
        n_cmp++; if (ad1 !== 12'h0A5) begin n_fail++; $display("FAIL rd1_addr: got %h want 0a5", ad1); end
        for (int t = 1; t <= 10; t++) begin
            tick();
            esv = (t >= 2) && (t <= 9);
            n_cmp++; if (sv1 !== esv) begin n_fail++; $display("FAIL rd1_svalid t%0d: got %b want %b", t, sv1, esv); end
            n_cmp++; if (ren1 !== 1'b0) begin n_fail++; $display("FAIL rd1_ren_extra t%0d: got %b want 0", t, ren1); end
            if (esv) begin
                n_cmp++; if (srd1 !== d[t-2]) begin n_fail++; $display("FAIL rd1_bit t%0d: got %b want %b", t, srd1, d[t-2]); end
            end
        end
        n_cmp++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL rd1_sready: got %b want 1", rdy1); end
    endtask

    task automatic test_burst_write_wrap();
        logic [7:0]  wdat [4];
        logic [11:0] eadr [4];
        wdat = '{8'h11, 8'h22, 8'h33, 8'h44};
        eadr = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        sel3 = 1'b0;
        send_hdr(1'b1, 12'hFFE, 4'd3);
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < DW; i++) begin
                drive_bit(wdat[b][i], 1'b1);
                if (i < DW - 1) begin
                    n_cmp++; if (wen1 !== 1'b0) begin n_fail++; $display("FAIL bw_gap b%0d i%0d: got %b want 0", b, i, wen1); end
                end
            end
            n_cmp++; if (wen1 !== 1'b1) begin n_fail++; $display("FAIL bw_wen b%0d: got %b want 1", b, wen1); end
            n_cmp++; if (ad1 !== eadr[b]) begin n_fail++; $display("FAIL bw_addr b%0d: got %h want %h", b, ad1, eadr[b]); end
            n_cmp++; if (wd1 !== wdat[b]) begin n_fail++; $display("FAIL bw_data b%0d: got %h want %h", b, wd1, wdat[b]); end
            n_cmp++; if (rdy1 !== (b == 3)) begin n_fail++; $display("FAIL bw_sready b%0d: got %b", b, rdy1); end
        end
        mv = 1'b0;
        tick();
    endtask

    task automatic test_burst_read_lat3();
        logic [7:0] w0, w1;
        logic eren, esv, ebit;
        w0 = 8'hA5; w1 = 8'h5A;
        mem3[12'h010] = w0;
        mem3[12'h011] = w1;
        sel3 = 1'b1;
        send_hdr(1'b0, 12'h010, 4'd1);
        n_cmp++; if (ren3 !== 1'b1) begin n_fail++; $display("FAIL br_ren0: got %b want 1", ren3); end
        n_cmp++; if (ad3 !== 12'h010) begin n_fail++; $display("FAIL br_addr0: got %h want 010", ad3); end
        for (int t = 1; t <= 24; t++) begin
            tick();
            eren = (t == 12);
            esv  = (t >= 4 && t <= 11) || (t >= 16 && t <= 23);
            ebit = (t >= 4 && t <= 11) ? w0[t-4] : ((t >= 16 && t <= 23) ? w1[t-16] : 1'b0);
            n_cmp++; if (ren3 !== eren) begin n_fail++; $display("FAIL br_ren t%0d: got %b want %b", t, ren3, eren); end
            n_cmp++; if (sv3 !== esv) begin n_fail++; $display("FAIL br_svalid t%0d: got %b want %b", t, sv3, esv); end
            n_cmp++; if (wen3 !== 1'b0) begin n_fail++; $display("FAIL br_wen t%0d: got %b want 0", t, wen3); end
            if (esv) begin
                n_cmp++; if (srd3 !== ebit) begin n_fail++; $display("FAIL br_bit t%0d: got %b want %b", t, srd3, ebit); end
            end
            if (t == 12) begin
                n_cmp++; if (ad3 !== 12'h011) begin n_fail++; $display("FAIL br_addr1: got %h want 011", ad3); end
            end
        end
        n_cmp++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL br_sready: got %b want 1", rdy3); end
        sel3 = 1'b0;
    endtask

    task automatic test_stall();
        logic [11:0] a;
        logic [7:0]  d;
        a = 12'h2C7; d = 8'h96;
        sel3 = 1'b0;
        smode = 1'b1;
        for (int i = 0; i < AW; i++) begin
            drive_bit(a[i], 1'b1);
            if (i == 4) begin
                for (int k = 0; k < 5; k++) drive_bit(~a[5], 1'b0);
                n_cmp++; if (rdy1 !== 1'b0) begin n_fail++; $display("FAIL st_sready: got %b want 0", rdy1); end
            end
        end
        for (int i = 0; i < BW; i++) drive_bit(1'b0, 1'b1);
        for (int i = 0; i < DW; i++) begin
            drive_bit(d[i], 1'b1);
            if (i == 3) begin
                for (int k = 0; k < 5; k++) begin
                    drive_bit(~d[4], 1'b0);
                    n_cmp++; if (wen1 !== 1'b0) begin n_fail++; $display("FAIL st_wen_stall k%0d: got %b want 0", k, wen1); end
                end
            end
            if (i == DW - 2) begin
                n_cmp++; if (wen1 !== 1'b0) begin n_fail++; $display("FAIL st_wen_early: got %b want 0", wen1); end
            end
        end
        mv = 1'b0;
        n_cmp++; if (wen1 !== 1'b1) begin n_fail++; $display("FAIL st_wen: got %b want 1", wen1); end
        n_cmp++; if (ad1 !== 12'h2C7) begin n_fail++; $display("FAIL st_addr: got %h want 2c7", ad1); end
        n_cmp++; if (wd1 !== 8'h96) begin n_fail++; $display("FAIL st_data: got %h want 96", wd1); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        logic seen;
        mem1[12'h100] = 8'hFF;
        sel3 = 1'b0;
        send_hdr(1'b0, 12'h100, 4'd2);
        for (int t = 1; t <= 5; t++) tick();
        n_cmp++; if (sv1 !== 1'b1 || srd1 !== 1'b1) begin n_fail++; $display("FAIL rr_bit3: got sv=%b sd=%b want 1 1", sv1, srd1); end
        rstn = 1'b0;
        tick();
        n_cmp++; if (sv1 !== 1'b0) begin n_fail++; $display("FAIL rr_svalid: got %b want 0", sv1); end
        n_cmp++; if (srd1 !== 1'b0) begin n_fail++; $display("FAIL rr_srdata: got %b want 0", srd1); end
        n_cmp++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL rr_sready: got %b want 1", rdy1); end
        n_cmp++; if (ren1 !== 1'b0) begin n_fail++; $display("FAIL rr_ren: got %b want 0", ren1); end
        rstn = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (ren1 === 1'b1 || sv1 === 1'b1 || wen1 === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rr_quiet: got activity=%b want 0", seen); end
        send_hdr(1'b1, 12'h333, 4'd0);
        for (int i = 0; i < DW; i++) drive_bit(i[0] ? 1'b1 : 1'b0, 1'b1);
        mv = 1'b0;
        n_cmp++; if (wen1 !== 1'b1) begin n_fail++; $display("FAIL rr_wr_wen: got %b want 1", wen1); end
        n_cmp++; if (ad1 !== 12'h333) begin n_fail++; $display("FAIL rr_wr_addr: got %h want 333", ad1); end
        n_cmp++; if (wd1 !== 8'hAA) begin n_fail++; $display("FAIL rr_wr_data: got %h want aa", wd1); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_burst_write_wrap();
        test_burst_read_lat3();
        test_stall();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
